// File: rtl/sb_cycle_ctl_if.sv
// Host request / sequencer-bus signal bundle for sb_cycle_ctl.
// slave = the cycle controller, master = host plus FEC decoder side.
interface sb_cycle_ctl_if;
    logic       HREQ;
    logic       HREAD;
    logic       HREGSPACE;
    logic [8:0] HADDR;
    logic       HACK;
    logic       HBERR;
    logic       BUSY;
    logic [8:0] BA;
    logic       BSBREAD_n;
    logic       BREGSPACE;
    logic       BSBSELECT;
    logic       BDTACK_REQ_n;
    logic       BDATA_LE;

    modport slave (
        input  HREQ, HREAD, HREGSPACE, HADDR, BDTACK_REQ_n,
        output HACK, HBERR, BUSY, BA, BSBREAD_n, BREGSPACE, BSBSELECT, BDATA_LE
    );

    modport master (
        output HREQ, HREAD, HREGSPACE, HADDR, BDTACK_REQ_n,
        input  HACK, HBERR, BUSY, BA, BSBREAD_n, BREGSPACE, BSBSELECT, BDATA_LE
    );
endinterface

// File: rtl/sb_cycle_ctl.sv
// SB cycle controller: host request -> timed BA/BSBREAD_n/BREGSPACE/BSBSELECT cycle.
// Optional bus-error timeout in SELECT is enabled by defining SB_TIMEOUT_EN.
module sb_cycle_ctl #(
    parameter int SETUP_CYC   = 2,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input logic           CLK,
    input logic           RESET,
    sb_cycle_ctl_if.slave sb
);
    localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || HOLD_CYC < 1 || TIMEOUT_CYC < 4) begin : g_param_check
        $error("sb_cycle_ctl: SETUP_CYC/HOLD_CYC must be >=1 and TIMEOUT_CYC >=4");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SELECT, S_STROBE, S_HOLD, S_ACK, S_WREL
    } state_t;

    state_t        state_q;
    logic          dtk_meta_q;
    logic          dtk_s_q;
    logic [SW-1:0] setup_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic [8:0]    ba_q;
    logic          rd_n_q;
    logic          regsp_q;
    logic          sel_q;
    logic          hack_q;
    logic          busy_q;
    logic          le_q;

`ifdef SB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] timer_q;
    logic          err_q;
    logic          hberr_q;
`endif

    // DTACK comes from another clock domain; presetting to 1 keeps it inactive after reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dtk_meta_q <= 1'b1;
            dtk_s_q    <= 1'b1;
        end else begin
            dtk_meta_q <= sb.BDTACK_REQ_n;
            dtk_s_q    <= dtk_meta_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            setup_cnt_q <= '0;
            hold_cnt_q  <= '0;
            ba_q        <= '0;
            rd_n_q      <= 1'b1;
            regsp_q     <= 1'b0;
            sel_q       <= 1'b0;
            hack_q      <= 1'b0;
            busy_q      <= 1'b0;
            le_q        <= 1'b0;
`ifdef SB_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
            hberr_q     <= 1'b0;
`endif
        end else begin
            hack_q <= 1'b0;
            le_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef SB_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                    // A DTACK still asserted from elsewhere blocks the start of a new cycle.
                    if (sb.HREQ && dtk_s_q) begin
                        ba_q        <= sb.HADDR;
                        rd_n_q      <= ~sb.HREAD;
                        regsp_q     <= sb.HREGSPACE;
                        setup_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (setup_cnt_q == SETUP_LAST) begin
                        sel_q   <= 1'b1;
`ifdef SB_TIMEOUT_EN
                        timer_q <= '0;
`endif
                        state_q <= S_SELECT;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 1'b1;
                    end
                end
                S_SELECT: begin
                    // DTACK is tested first so it wins over a simultaneous timeout.
                    if (!dtk_s_q) begin
                        le_q    <= ~rd_n_q;
                        state_q <= S_STROBE;
                    end
`ifdef SB_TIMEOUT_EN
                    else if (timer_q == TIMER_LAST) begin
                        err_q      <= 1'b1;
                        sel_q      <= 1'b0;
                        hold_cnt_q <= '0;
                        state_q    <= S_HOLD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                S_STROBE: begin
                    sel_q      <= 1'b0;
                    hold_cnt_q <= '0;
                    state_q    <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hack_q  <= 1'b1;
`ifdef SB_TIMEOUT_EN
                        hberr_q <= err_q;
`endif
                        state_q <= S_ACK;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                S_ACK: begin
`ifdef SB_TIMEOUT_EN
                    hberr_q <= 1'b0;
`endif
                    state_q <= S_WREL;
                end
                S_WREL: begin
                    if (!sb.HREQ) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    sel_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sb.BA        = ba_q;
    assign sb.BSBREAD_n = rd_n_q;
    assign sb.BREGSPACE = regsp_q;
    assign sb.BSBSELECT = sel_q;
    assign sb.HACK      = hack_q;
    assign sb.BUSY      = busy_q;
    assign sb.BDATA_LE  = le_q;
`ifdef SB_TIMEOUT_EN
    assign sb.HBERR     = hberr_q;
`else
    assign sb.HBERR     = 1'b0;
`endif
endmodule

// File: tb/tb_sb_cycle_ctl.sv
// Self-checking bench for sb_cycle_ctl: vector table, hand-written corner sequences,
// and randomized transactions checked against a per-clock timeline model.
module tb_sb_cycle_ctl;
    localparam int SETUP_CYC   = 2;
    localparam int HOLD_CYC    = 1;
    localparam int TIMEOUT_CYC = 64;
    // Timeline in clocks after the edge that samples HREQ; DTACK needs 3 edges through the synchroniser.
    localparam int T_SEL = SETUP_CYC;
    localparam int T_STB = T_SEL + 3;
    localparam int T_ACK = T_STB + 1 + HOLD_CYC;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic dec_force_low = 1'b0;
    logic dec_silent = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    sb_cycle_ctl_if sb();

    // Decoder model: acknowledges while selected unless silenced or forced.
    assign sb.BDTACK_REQ_n = dec_force_low ? 1'b0 : (dec_silent ? 1'b1 : ~sb.BSBSELECT);

    sb_cycle_ctl #(
        .SETUP_CYC  (SETUP_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .sb   (sb)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"},   32'(sb.BSBSELECT), 32'd0);
        check({tag, "_hack"},  32'(sb.HACK),      32'd0);
        check({tag, "_hberr"}, 32'(sb.HBERR),     32'd0);
        check({tag, "_le"},    32'(sb.BDATA_LE),  32'd0);
        check({tag, "_busy"},  32'(sb.BUSY),      32'd0);
        check({tag, "_ba"},    32'(sb.BA),        32'd0);
        check({tag, "_rdn"},   32'(sb.BSBREAD_n), 32'd1);
        check({tag, "_rs"},    32'(sb.BREGSPACE), 32'd0);
    endtask

    // Drops HREQ and waits (bounded) for the controller to return to idle.
    task automatic wait_idle(input string name);
        int n;
        sb.HREQ = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (sb.BUSY && n < 8);
        check(name, 32'(sb.BUSY), 32'd0);
    endtask

    task automatic wait_hack(input string name, input int limit, output int got_k, output logic berr);
        got_k = -1;
        berr  = 1'b0;
        for (int k = 0; k < limit && got_k < 0; k++) begin
            @(negedge CLK);
            if (sb.HACK) begin
                got_k = k;
                berr  = sb.HBERR;
            end
        end
        if (got_k < 0) begin
            n_chk++;
            $display("FAIL %s: no HACK within %0d clocks", name, limit);
        end
    endtask

    // One complete host transaction with per-clock checks against the timeline model.
    task automatic run_txn(input logic [8:0] a, input bit rd, input bit rs, input int gap,
                           input bit drop_early, input bit scramble, input int rel,
                           output int ack_k, output int le_cnt, output int sel_cnt,
                           output logic [8:0] ba0, output logic rdn0, output logic rs0);
        int wait_n;
        int rel_eff;
        rel_eff = drop_early ? 0 : rel;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        check("idle_before", 32'(sb.BUSY), 32'd0);
        sb.HREQ = 1'b1;
        sb.HADDR = a;
        sb.HREAD = rd;
        sb.HREGSPACE = rs;
        ack_k = -1;
        le_cnt = 0;
        sel_cnt = 0;
        ba0 = '0;
        rdn0 = 1'b0;
        rs0 = 1'b0;
        for (int k = 0; k < T_ACK + 10 && ack_k < 0; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                ba0 = sb.BA;
                rdn0 = sb.BSBREAD_n;
                rs0 = sb.BREGSPACE;
            end
            check("busy",    32'(sb.BUSY),      32'd1);
            check("ba",      32'(sb.BA),        32'(a));
            check("rd_n",    32'(sb.BSBREAD_n), 32'(!rd));
            check("regsp",   32'(sb.BREGSPACE), 32'(rs));
            check("select",  32'(sb.BSBSELECT), 32'(k >= T_SEL && k <= T_STB));
            check("data_le", 32'(sb.BDATA_LE),  32'(rd && k == T_STB));
            check("hack",    32'(sb.HACK),      32'(k == T_ACK));
            check("hberr",   32'(sb.HBERR),     32'd0);
            if (sb.BDATA_LE) le_cnt++;
            if (sb.BSBSELECT) sel_cnt++;
            if (sb.HACK) ack_k = k;
            if (k == 0 && scramble) begin
                sb.HADDR = 9'($urandom);
                sb.HREAD = 1'($urandom);
                sb.HREGSPACE = 1'($urandom);
            end
            if (k == 0 && drop_early) sb.HREQ = 1'b0;
        end
        if (ack_k < 0) begin
            n_chk++;
            $display("FAIL ack_wait: no HACK within %0d clocks", T_ACK + 10);
        end
        for (int j = 0; j < rel_eff; j++) begin
            @(negedge CLK);
            check("held_busy",   32'(sb.BUSY),      32'd1);
            check("held_nohack", 32'(sb.HACK),      32'd0);
            check("held_nosel",  32'(sb.BSBSELECT), 32'd0);
        end
        sb.HREQ = 1'b0;
        wait_n = 0;
        do begin
            @(negedge CLK);
            wait_n++;
            check("rel_nohack", 32'(sb.HACK), 32'd0);
        end while (sb.BUSY && wait_n < 6);
        check("release_lat", 32'(wait_n), 32'((rel_eff == 0) ? 2 : 1));
    endtask

    typedef struct {
        logic [8:0] haddr;
        bit         hread;
        bit         hregspace;
        int         rel;
        logic [8:0] exp_ba;
        bit         exp_rdn;
        bit         exp_rs;
        int         exp_le;
        int         exp_sel;
        int         exp_ack;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        int         ack_k, le_cnt, sel_cnt, n;
        logic [8:0] ba0;
        logic       rdn0, rs0, berr;
        logic [8:0] ra;
        bit         rrd, rrs;

        vecs[0] = '{9'h041, 1'b0, 1'b1, 0, 9'h041, 1'b1, 1'b1, 0, 4, 7};
        vecs[1] = '{9'h1F0, 1'b1, 1'b0, 0, 9'h1F0, 1'b0, 1'b0, 1, 4, 7};
        vecs[2] = '{9'h000, 1'b1, 1'b1, 1, 9'h000, 1'b0, 1'b1, 1, 4, 7};
        vecs[3] = '{9'h1FF, 1'b0, 1'b0, 2, 9'h1FF, 1'b1, 1'b0, 0, 4, 7};
        vecs[4] = '{9'h0AA, 1'b1, 1'b1, 6, 9'h0AA, 1'b0, 1'b1, 1, 4, 7};

        sb.HREQ = 1'b0;
        sb.HREAD = 1'b0;
        sb.HREGSPACE = 1'b0;
        sb.HADDR = '0;

        @(negedge CLK);
        check_reset_vals("por");
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_vals("idle");

        // Table vectors; the last one holds HREQ 6 clocks after HACK, then gap of 5 low clocks.
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].haddr, vecs[i].hread, vecs[i].hregspace, (i == 4) ? 0 : 4,
                    1'b0, 1'b0, vecs[i].rel, ack_k, le_cnt, sel_cnt, ba0, rdn0, rs0);
            check($sformatf("vec%0d_ba", i),  32'(ba0),     32'(vecs[i].exp_ba));
            check($sformatf("vec%0d_rdn", i), 32'(rdn0),    32'(vecs[i].exp_rdn));
            check($sformatf("vec%0d_rs", i),  32'(rs0),     32'(vecs[i].exp_rs));
            check($sformatf("vec%0d_le", i),  32'(le_cnt),  32'(vecs[i].exp_le));
            check($sformatf("vec%0d_sel", i), 32'(sel_cnt), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_ack", i), 32'(ack_k),   32'(vecs[i].exp_ack));
        end
        run_txn(9'h123, 1'b0, 1'b1, 4, 1'b0, 1'b0, 0, ack_k, le_cnt, sel_cnt, ba0, rdn0, rs0);
        check("reassert_ack", 32'(ack_k), 32'(T_ACK));

        // Silent decoder.
        @(negedge CLK);
        dec_silent = 1'b1;
        sb.HREQ = 1'b1;
        sb.HADDR = 9'h0C3;
        sb.HREAD = 1'b1;
        sb.HREGSPACE = 1'b0;
`ifdef SB_TIMEOUT_EN
        ack_k = -1;
        sel_cnt = 0;
        le_cnt = 0;
        berr = 1'b0;
        for (int k = 0; k < T_SEL + TIMEOUT_CYC + HOLD_CYC + 10 && ack_k < 0; k++) begin
            @(negedge CLK);
            if (sb.BSBSELECT) sel_cnt++;
            if (sb.BDATA_LE) le_cnt++;
            if (sb.HACK) begin
                ack_k = k;
                berr = sb.HBERR;
            end
        end
        check("to_sel_cnt", 32'(sel_cnt), 32'(TIMEOUT_CYC));
        check("to_ack_k",   32'(ack_k),   32'(T_SEL + TIMEOUT_CYC + HOLD_CYC));
        check("to_le",      32'(le_cnt),  32'd0);
        check("to_hberr",   32'(berr),    32'd1);
        @(negedge CLK);
        check("to_hack_1clk",  32'(sb.HACK),  32'd0);
        check("to_hberr_1clk", 32'(sb.HBERR), 32'd0);
        dec_silent = 1'b0;
        wait_idle("to_idle");
`else
        sel_cnt = 0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (sb.BSBSELECT) sel_cnt++;
            if (sb.HACK) n++;
        end
        check("wait_sel_held", 32'(sb.BSBSELECT), 32'd1);
        check("wait_busy",     32'(sb.BUSY),      32'd1);
        check("wait_sel_cnt",  32'(sel_cnt),      32'(100 - T_SEL));
        check("wait_no_hack",  32'(n),            32'd0);
        dec_silent = 1'b0;
        wait_hack("wait_late_ack", 12, ack_k, berr);
        check("wait_late_ack_k", 32'(ack_k), 32'(3 + 1 + HOLD_CYC - 1));
        check("wait_no_hberr",   32'(berr),  32'd0);
        wait_idle("wait_idle");
`endif
        run_txn(9'h0F0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0, ack_k, le_cnt, sel_cnt, ba0, rdn0, rs0);
        check("after_silent_ack", 32'(ack_k), 32'(T_ACK));

        // Reset while BSBSELECT is high.
        @(negedge CLK);
        sb.HREQ = 1'b1;
        sb.HADDR = 9'h155;
        sb.HREAD = 1'b0;
        sb.HREGSPACE = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!sb.BSBSELECT && n < 10);
        check("rst_sel_seen", 32'(sb.BSBSELECT), 32'd1);
        #2 RESET = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge CLK);
        sb.HREQ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (sb.HACK || sb.BUSY) n++;
        end
        check("rst_no_hack", 32'(n), 32'd0);
        run_txn(9'h0AB, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0, ack_k, le_cnt, sel_cnt, ba0, rdn0, rs0);
        check("rst_next_le", 32'(le_cnt), 32'd1);

        // DTACK stuck low blocks the start; release starts the cycle 3 clocks later.
        @(negedge CLK);
        dec_force_low = 1'b1;
        repeat (3) @(negedge CLK);
        sb.HREQ = 1'b1;
        sb.HADDR = 9'h066;
        sb.HREAD = 1'b0;
        sb.HREGSPACE = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (sb.BUSY || sb.BSBSELECT) n++;
        end
        check("stuck_idle", 32'(n), 32'd0);
        dec_force_low = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!sb.BUSY && n < 8);
        check("stuck_release_lat", 32'(n), 32'd3);
        check("stuck_ba", 32'(sb.BA), 32'h066);
        wait_hack("stuck_ack", 15, ack_k, berr);
        check("stuck_ack_k", 32'(ack_k), 32'(T_ACK - 1));
        wait_idle("stuck_idle_end");

        // Randomized transactions against the timeline model.
        for (int i = 0; i < 40; i++) begin
            ra = 9'($urandom);
            rrd = 1'($urandom);
            rrs = 1'($urandom);
            run_txn(ra, rrd, rrs, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                    1'($urandom), $urandom_range(0, 3), ack_k, le_cnt, sel_cnt, ba0, rdn0, rs0);
            check("rnd_le_cnt",  32'(le_cnt),  32'(rrd ? 1 : 0));
            check("rnd_sel_cnt", 32'(sel_cnt), 32'(T_STB - T_SEL + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
